program_loader: RTL

- Upstream feeder for the multicycle CPU's external memory-load port.
- Receives a byte stream (length header + 16-bit program words) over a valid/ready handshake and assembles it into words.
- Writes each word into CPU memory through the Mem_Addr/Write_Data/MemWrite1 port while holding the CPU in reset.
- Releases the CPU from reset once the load completes.

---
 rtl/program_loader_pkg.sv | 31 +++
 rtl/program_loader_byte_pair_assembler.sv | 52 +++++
 rtl/program_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader_pkg                                           |
// | Description : Shared types and constants for the program loader: the      |
// |               loader state enumeration and the byte/word widths.           |
// | Ports       : none (package)                                               |
// | Options     : PROGRAM_LOADER_CHECKSUM_EN (CS_HI/CS_LO/ERROR states are     |
// |               only reachable when this macro is defined)                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package program_loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LEN_HI = 4'd1,
        LEN_LO = 4'd2,
        DAT_HI = 4'd3,
        DAT_LO = 4'd4,
        WRITE  = 4'd5,
        CS_HI  = 4'd6,
        CS_LO  = 4'd7,
        SETTLE = 4'd8,
        DONE   = 4'd9,
        ERROR  = 4'd10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_pair_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader_byte_pair_assembler                           |
// | Description : Valid/ready byte sink that pairs consecutive bytes into      |
// |               big-endian 16-bit words. The word is presented on the same   |
// |               cycle the low byte is accepted, qualified by o_word_valid.   |
// | Ports       : clk, rst_n (sync, active-low), i_enable (loader can take a   |
// |               byte), i_clear (restart pairing at high byte), i_byte,       |
// |               i_valid, o_ready, o_accept (byte taken this cycle),          |
// |               o_word_valid, o_word                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module program_loader_byte_pair_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_accept,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [BYTE_W-1:0] r_hi_byte;
    logic              r_lo_phase;   // 1: next accepted byte completes a word

    assign o_ready      = i_enable;
    assign o_accept     = i_enable && i_valid;
    assign o_word_valid = o_accept && r_lo_phase;
    // Low byte bypasses the register so the loader sees the word immediately.
    assign o_word       = {r_hi_byte, i_byte};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi_byte  <= '0;
            r_lo_phase <= 1'b0;
        end else if (i_clear) begin
            r_lo_phase <= 1'b0;
        end else if (o_accept) begin
            r_lo_phase <= ~r_lo_phase;
            if (!r_lo_phase) begin
                r_hi_byte <= i_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader                                               |
// | Description : Loads a length-prefixed stream of 16-bit program words into  |
// |               CPU memory while holding the CPU in reset, then releases     |
// |               the CPU RELEASE_DELAY cycles after the load completes.       |
// | Ports       : clock, reset (sync, active-low), start, in_byte/in_valid/    |
// |               in_ready (byte stream), Mem_Addr/Write_Data/MemWrite1/       |
// |               MemRead1 (CPU memory port), cpu_reset, busy, done, error,    |
// |               words_loaded                                                 |
// | Options     : PROGRAM_LOADER_CHECKSUM_EN - receive and verify a trailing   |
// |               16-bit checksum (sum of length and data words, mod 2^16)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR     = 16'h0000,
    parameter int                RELEASE_DELAY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] Mem_Addr,
    output logic [WORD_W-1:0] Write_Data,
    output logic              MemWrite1,
    output logic              MemRead1,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] words_loaded
);

    localparam logic [7:0] c_SETTLE_LAST = 8'(RELEASE_DELAY - 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t c_TAIL = CS_HI;
`else
    localparam state_t c_TAIL = SETTLE;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic              w_rx_en;
    logic              w_clear;
    logic              w_accept;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] r_len;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_words;
    logic [WORD_W-1:0] w_words_inc;
    logic [7:0]        r_settle_cnt;

    assign w_rx_en     = r_state inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CS_HI, CS_LO};
    assign w_words_inc = r_words + 16'd1;

    program_loader_byte_pair_assembler u_assembler (
        .clk          (clock),
        .rst_n        (reset),
        .i_enable     (w_rx_en),
        .i_clear      (w_clear),
        .i_byte       (in_byte),
        .i_valid      (in_valid),
        .o_ready      (in_ready),
        .o_accept     (w_accept),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;

    // Running sum starts at zero on start, so the length is its first term.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_clear) begin
            r_sum <= '0;
        end else if (w_word_valid && (r_state == LEN_LO || r_state == DAT_LO)) begin
            r_sum <= r_sum + w_word;
        end
    end

    assign error = (r_state == ERROR);
`else
    assign error = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_state_next = LEN_HI;
                    w_clear      = 1'b1;
                end
            end
            LEN_HI: if (w_accept)     w_state_next = LEN_LO;
            LEN_LO: if (w_word_valid) w_state_next = (w_word == '0) ? c_TAIL : DAT_HI;
            DAT_HI: if (w_accept)     w_state_next = DAT_LO;
            DAT_LO: if (w_word_valid) w_state_next = WRITE;
            WRITE:  w_state_next = (w_words_inc == r_len) ? c_TAIL : DAT_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CS_HI:  if (w_accept)     w_state_next = CS_LO;
            CS_LO:  if (w_word_valid) w_state_next = (w_word == r_sum) ? SETTLE : ERROR;
`endif
            SETTLE: if (r_settle_cnt == c_SETTLE_LAST) w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: length, write address/data, word count, release timer
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_len        <= '0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
            r_words      <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (w_clear) begin
                r_addr  <= BASE_ADDR;
                r_words <= '0;
            end
            if (r_state == LEN_LO && w_word_valid) begin
                r_len <= w_word;
            end
            if (r_state == DAT_LO && w_word_valid) begin
                r_wdata <= w_word;
            end
            if (r_state == WRITE) begin
                r_addr  <= r_addr + 16'd1;   // wraps FFFF -> 0000
                r_words <= w_words_inc;
            end
            // Counts cycles spent in SETTLE; idle at zero everywhere else.
            if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

    assign Mem_Addr     = r_addr;
    assign Write_Data   = r_wdata;
    assign MemWrite1    = (r_state == WRITE);
    assign MemRead1     = 1'b0;
    assign cpu_reset    = (r_state != DONE);
    assign busy         = !(r_state inside {IDLE, DONE, ERROR});
    assign done         = (r_state == DONE);
    assign words_loaded = r_words;

endmodule
`default_nettype wire
